// File: rtl/button_conditioner_if.sv
// button_conditioner_if
//   Groups the raw front-panel levels and the conditioned outputs of the
//   button conditioner.
//   slave  : conditioner side (raw levels in, pulses / selector out)
//   master : panel / consumer side (raw levels out, pulses / selector in)
//   PB1_raw, PB2_raw, PB3_raw : asynchronous button levels, high = pressed
//   A_raw[1:0]                : asynchronous selector switch levels
//   PB1, PB2, PB3             : single-cycle press pulses
//   A[1:0], A_chg             : debounced selector and its change pulse
interface button_conditioner_if;
    logic       PB1_raw;
    logic       PB2_raw;
    logic       PB3_raw;
    logic [1:0] A_raw;
    logic       PB1;
    logic       PB2;
    logic       PB3;
    logic [1:0] A;
    logic       A_chg;

    modport slave (
        input  PB1_raw, PB2_raw, PB3_raw, A_raw,
        output PB1, PB2, PB3, A, A_chg
    );

    modport master (
        output PB1_raw, PB2_raw, PB3_raw, A_raw,
        input  PB1, PB2, PB3, A, A_chg
    );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner
//   Synchronizes and debounces three push buttons and a 2-bit selector,
//   turns button presses into single-cycle pulses arbitrated by priority
//   (PB3 > PB2 > PB1) with a lockout until every button is released, and
//   reports debounced selector changes with a one-cycle A_chg pulse.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : button_conditioner_if.slave (raw levels in, conditioned out)
//
//   Arbiter states:
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_READY  | next debounced press is granted (highest priority wins)
//   ST_LOCKED | a press was granted; ignore presses until all released
module button_conditioner #(
    parameter int DB_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    button_conditioner_if.slave   bus
);

    localparam logic [7:0] TC        = 8'(DB_CYCLES - 1);
    localparam logic [0:0] ST_READY  = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [2:0] pb_s1, pb_s2;
    logic [1:0] a_s1, a_s2;

    logic [2:0] pb_db;
    logic [7:0] pb_cnt [3];
    logic [2:0] pb_upd;
    logic [2:0] pb_rise;

    logic [1:0] a_db;
    logic [1:0] a_cand;
    logic [7:0] a_cnt;
    logic       a_chg_q;

    logic [0:0] state;
    logic [2:0] pb_out;
    logic [2:0] grant;

    assign bus.PB1   = pb_out[0];
    assign bus.PB2   = pb_out[1];
    assign bus.PB3   = pb_out[2];
    assign bus.A     = a_db;
    assign bus.A_chg = a_chg_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pb_s1 <= 3'b000;
            pb_s2 <= 3'b000;
            a_s1  <= 2'b00;
            a_s2  <= 2'b00;
        end else begin
            pb_s1 <= {bus.PB3_raw, bus.PB2_raw, bus.PB1_raw};
            pb_s2 <= pb_s1;
            a_s1  <= bus.A_raw;
            a_s2  <= a_s1;
        end
    end

    // A level flips once it has differed for DB_CYCLES consecutive edges;
    // the press request is the rising flip itself, seen on the same edge.
    always_comb begin
        pb_upd  = 3'b000;
        pb_rise = 3'b000;
        for (int i = 0; i < 3; i++) begin
            pb_upd[i]  = (pb_s2[i] != pb_db[i]) && (pb_cnt[i] == TC);
            pb_rise[i] = pb_upd[i] && pb_s2[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pb_db <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                pb_cnt[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (pb_s2[i] == pb_db[i] || pb_upd[i]) begin
                    pb_cnt[i] <= 8'd0;
                end else begin
                    pb_cnt[i] <= pb_cnt[i] + 8'd1;
                end
                if (pb_upd[i]) begin
                    pb_db[i] <= pb_s2[i];
                end
            end
        end
    end

    always_comb begin
        grant = 3'b000;
        if (pb_rise[2]) begin
            grant = 3'b100;
        end else if (pb_rise[1]) begin
            grant = 3'b010;
        end else if (pb_rise[0]) begin
            grant = 3'b001;
        end
    end

    // Lock release looks at the registered levels, so the edge that frees
    // the arbiter never grants a press itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_READY;
            pb_out <= 3'b000;
        end else begin
            pb_out <= 3'b000;
            case (state)
                ST_READY: begin
                    if (|pb_rise) begin
                        pb_out <= grant;
                        state  <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (pb_db == 3'b000) begin
                        state <= ST_READY;
                    end
                end
                default: state <= ST_READY;
            endcase
        end
    end

    // The selector counts toward a candidate value; a different value
    // arriving mid-count becomes the new candidate with a fresh count.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_db    <= 2'b00;
            a_cand  <= 2'b00;
            a_cnt   <= 8'd0;
            a_chg_q <= 1'b0;
        end else begin
            a_chg_q <= 1'b0;
            if (a_s2 == a_db) begin
                a_cnt <= 8'd0;
            end else if (a_cnt != 8'd0 && a_s2 == a_cand) begin
                if (a_cnt == TC) begin
                    a_db    <= a_s2;
                    a_cnt   <= 8'd0;
                    a_chg_q <= 1'b1;
                end else begin
                    a_cnt <= a_cnt + 8'd1;
                end
            end else begin
                a_cand <= a_s2;
                a_cnt  <= 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Drives directed press/glitch/priority/reset scenarios followed by random
//   held levels, and compares every cycle against a reference model that
//   works from recorded raw history: a level changes once the value seen
//   past the two synchronizer stages has been identical and different from
//   the current level for DB consecutive reset-free edges.
module tb_button_conditioner;

    localparam int DB   = 4;
    localparam int MAXE = 4000;

    logic clk;
    logic reset;

    button_conditioner_if bus ();

    button_conditioner #(.DB_CYCLES(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int raw_h [MAXE][4];
    bit rst_h [MAXE];
    int k_edge = -1;

    int db_m     [4];
    int last_upd [4];
    bit lock_m;

    int n_vec = 0;
    int fails = 0;

    int pc [3];
    int last_pulse [3];
    int ac_cnt;
    int last_ac;

    function automatic int sync_seen(input int ch, input int k);
        if (k < 2) return 0;
        if (rst_h[k-1] || rst_h[k-2]) return 0;
        return raw_h[k-2][ch];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, expv, k_edge);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            pc[i] = 0;
            last_pulse[i] = -1;
        end
        ac_cnt  = 0;
        last_ac = -1;
    endtask

    task automatic tick(input bit r, input bit p1, input bit p2, input bit p3,
                        input logic [1:0] a);
        bit upd [4];
        int v [4];
        logic [2:0] exp_pb;
        bit ok;
        @(negedge clk);
        reset       = r;
        bus.PB1_raw = p1;
        bus.PB2_raw = p2;
        bus.PB3_raw = p3;
        bus.A_raw   = a;
        @(posedge clk);
        k_edge++;
        if (k_edge >= MAXE) begin
            $display("FAIL edge_budget: observed %0d edges, limit %0d", k_edge, MAXE);
            $fatal(1, "edge budget exhausted");
        end
        rst_h[k_edge]     = r;
        raw_h[k_edge][0]  = p1;
        raw_h[k_edge][1]  = p2;
        raw_h[k_edge][2]  = p3;
        raw_h[k_edge][3]  = int'(a);
        exp_pb = 3'b000;
        upd[3] = 0;
        if (r) begin
            for (int c = 0; c < 4; c++) begin
                db_m[c]     = 0;
                last_upd[c] = k_edge;
            end
            lock_m = 0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                v[c]   = sync_seen(c, k_edge);
                upd[c] = 0;
                if (v[c] != db_m[c] && last_upd[c] <= k_edge - DB) begin
                    ok = 1;
                    for (int j = k_edge - DB + 1; j <= k_edge; j++) begin
                        if (j < 0 || rst_h[j] || sync_seen(c, j) != v[c]) ok = 0;
                    end
                    upd[c] = ok;
                end
            end
            if (!lock_m) begin
                if (upd[2] && v[2] == 1) begin
                    exp_pb = 3'b100; lock_m = 1;
                end else if (upd[1] && v[1] == 1) begin
                    exp_pb = 3'b010; lock_m = 1;
                end else if (upd[0] && v[0] == 1) begin
                    exp_pb = 3'b001; lock_m = 1;
                end
            end else if (db_m[0] == 0 && db_m[1] == 0 && db_m[2] == 0) begin
                lock_m = 0;
            end
            for (int c = 0; c < 4; c++) begin
                if (upd[c]) begin
                    db_m[c]     = v[c];
                    last_upd[c] = k_edge;
                end
            end
        end
        #1;
        chk("PB1",   8'(bus.PB1),   8'(exp_pb[0]));
        chk("PB2",   8'(bus.PB2),   8'(exp_pb[1]));
        chk("PB3",   8'(bus.PB3),   8'(exp_pb[2]));
        chk("A",     8'(bus.A),     8'(db_m[3]));
        chk("A_chg", 8'(bus.A_chg), 8'(upd[3]));
        chk("onehot", 8'($onehot0({bus.PB3, bus.PB2, bus.PB1})), 8'd1);
        if (bus.PB1 === 1'b1) begin pc[0]++; last_pulse[0] = k_edge; end
        if (bus.PB2 === 1'b1) begin pc[1]++; last_pulse[1] = k_edge; end
        if (bus.PB3 === 1'b1) begin pc[2]++; last_pulse[2] = k_edge; end
        if (bus.A_chg === 1'b1) begin ac_cnt++; last_ac = k_edge; end
    endtask

    task automatic hold(input int n, input bit r, input bit p1, input bit p2,
                        input bit p3, input logic [1:0] a);
        for (int i = 0; i < n; i++) tick(r, p1, p2, p3, a);
    endtask

    initial begin
        int rise_e;
        int rst_last;
        bit rr, q1, q2, q3;
        logic [1:0] qa;
        lock_m = 0;
        for (int c = 0; c < 4; c++) begin
            db_m[c] = 0;
            last_upd[c] = -1000;
        end
        clear_counts();
        reset = 1'b1;
        bus.PB1_raw = 1'b0; bus.PB2_raw = 1'b0; bus.PB3_raw = 1'b0; bus.A_raw = 2'b00;

        // reset state, then a single debounced PB1 press held long
        hold(3, 1, 0, 0, 0, 2'b00);
        chk("reset_outputs", 8'({bus.PB3, bus.PB2, bus.PB1, bus.A, bus.A_chg}), 8'd0);
        hold(7, 0, 0, 0, 0, 2'b00);
        clear_counts();
        tick(0, 1, 0, 0, 2'b00);
        rise_e = k_edge;
        hold(25, 0, 1, 0, 0, 2'b00);
        chk("press_pb1_count", 8'(pc[0]), 8'd1);
        chk("press_pb1_delay", 8'(last_pulse[0] - rise_e), 8'(DB + 1));
        chk("press_others", 8'(pc[1] + pc[2]), 8'd0);

        // glitches: short PB2 pulse, selector chatter
        hold(10, 0, 0, 0, 0, 2'b00);
        clear_counts();
        hold(3, 0, 0, 1, 0, 2'b00);
        hold(10, 0, 0, 0, 0, 2'b00);
        chk("glitch_pb2", 8'(pc[1]), 8'd0);
        for (int i = 0; i < 6; i++) begin
            hold(2, 0, 0, 0, 0, 2'b01);
            hold(2, 0, 0, 0, 0, 2'b10);
        end
        hold(8, 0, 0, 0, 0, 2'b00);
        chk("glitch_a_chg", 8'(ac_cnt), 8'd0);
        chk("glitch_a", 8'(bus.A), 8'd0);

        // simultaneous PB1+PB3, then release PB3 only
        clear_counts();
        hold(12, 0, 1, 0, 1, 2'b00);
        chk("prio_pb3", 8'(pc[2]), 8'd1);
        chk("prio_pb1", 8'(pc[0]), 8'd0);
        hold(12, 0, 1, 0, 0, 2'b00);
        chk("locked_pb1", 8'(pc[0]), 8'd0);

        // release all, then PB2
        hold(10, 0, 0, 0, 0, 2'b00);
        clear_counts();
        tick(0, 0, 1, 0, 2'b00);
        rise_e = k_edge;
        hold(12, 0, 0, 1, 0, 2'b00);
        chk("rearm_pb2_count", 8'(pc[1]), 8'd1);
        chk("rearm_pb2_delay", 8'(last_pulse[1] - rise_e), 8'(DB + 1));
        hold(8, 0, 0, 0, 0, 2'b00);

        // selector to 11 and back
        clear_counts();
        tick(0, 0, 0, 0, 2'b11);
        rise_e = k_edge;
        hold(12, 0, 0, 0, 0, 2'b11);
        chk("sel_value", 8'(bus.A), 8'd3);
        chk("sel_chg_count", 8'(ac_cnt), 8'd1);
        chk("sel_chg_delay", 8'(last_ac - rise_e), 8'(DB + 1));
        hold(12, 0, 0, 0, 0, 2'b00);
        chk("sel_back_count", 8'(ac_cnt), 8'd2);
        chk("sel_back_value", 8'(bus.A), 8'd0);

        // reset two edges into a PB1 count, button held throughout
        clear_counts();
        hold(2, 0, 1, 0, 0, 2'b00);
        hold(3, 1, 1, 0, 0, 2'b00);
        rst_last = k_edge;
        chk("midreset_pb1_during", 8'(pc[0]), 8'd0);
        hold(14, 0, 1, 0, 0, 2'b00);
        chk("midreset_pb1_count", 8'(pc[0]), 8'd1);
        chk("midreset_pb1_delay", 8'(last_pulse[0] - rst_last), 8'(DB + 2));

        // selector held through reset release
        clear_counts();
        hold(3, 1, 0, 0, 0, 2'b10);
        rst_last = k_edge;
        hold(12, 0, 0, 0, 0, 2'b10);
        chk("sel_reset_count", 8'(ac_cnt), 8'd1);
        chk("sel_reset_delay", 8'(last_ac - rst_last), 8'(DB + 2));
        hold(8, 0, 0, 0, 0, 2'b00);

        // random held levels, occasional reset, checked against the model
        for (int s = 0; s < 250; s++) begin
            rr = ($urandom_range(0, 24) == 0);
            q1 = ($urandom_range(0, 2) == 0);
            q2 = ($urandom_range(0, 2) == 0);
            q3 = ($urandom_range(0, 2) == 0);
            qa = 2'($urandom_range(0, 3));
            hold(rr ? 1 : $urandom_range(1, 10), rr, q1, q2, q3, qa);
        end
        hold(10, 0, 0, 0, 0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, fails);
        $finish;
    end

endmodule
